// File: rtl/hilo_pkg.sv
// Shared types and defaults for the HI/LO register unit.
package hilo_pkg;

  localparam int unsigned HILO_DATA_W     = 32;
  localparam int unsigned HILO_PIPE_DEPTH = 2;

  typedef struct packed {
    logic                   vhi;
    logic                   vlo;
    logic [HILO_DATA_W-1:0] hi;
    logic [HILO_DATA_W-1:0] lo;
  } hilo_entry_t;

  localparam hilo_entry_t HILO_RESET_ENTRY = '0;

  // Drop both valid bits when the entry is squashed; data is left as-is.
  function automatic hilo_entry_t hilo_squash(input hilo_entry_t e, input logic flush);
    hilo_entry_t r;
    r     = e;
    r.vhi = e.vhi & ~flush;
    r.vlo = e.vlo & ~flush;
    return r;
  endfunction

endpackage

// File: rtl/hilo_reg_unit_fwd_sel.sv
// Youngest-valid select across in-flight stages (index 0 youngest), falling back to arch.
module hilo_fwd_sel #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32
) (
  input  logic [DEPTH-1:0]        valid,
  input  logic [DEPTH-1:0][W-1:0] data,
  input  logic [W-1:0]            arch,
  output logic [W-1:0]            sel
);

  always_comb begin
    sel = arch;
    // Walk oldest to youngest so the youngest valid stage is written last.
    for (int unsigned k = DEPTH; k > 0; k--) begin
      if (valid[k-1]) sel = data[k-1];
    end
  end

endmodule

// File: rtl/hilo_reg_unit.sv
// HI/LO register pair with a squashable commit pipeline and read forwarding.
// Define HILO_FORWARD_EN for forwarding; otherwise reads see arch only and Stall flags hazards.
module hilo_reg_unit
  import hilo_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = HILO_PIPE_DEPTH,
  parameter int unsigned DATA_W     = HILO_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WrHiEn,
  input  logic              WrLoEn,
  input  logic [DATA_W-1:0] WrHiData,
  input  logic [DATA_W-1:0] WrLoData,
  input  logic              ReadHi,
  input  logic              ReadLo,
  input  logic              Flush,
  output logic [DATA_W-1:0] HiOut,
  output logic [DATA_W-1:0] LoOut,
  output logic              Stall,
  output logic              Pending
);

`ifdef HILO_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Entry width comes from hilo_entry_t, so DATA_W is expected to equal HILO_DATA_W.
  hilo_entry_t stage [PIPE_DEPTH];
  logic [DATA_W-1:0] hi_arch, lo_arch;

  logic [PIPE_DEPTH-1:0]             vhi_vec, vlo_vec;
  logic [PIPE_DEPTH-1:0][DATA_W-1:0] hi_vec, lo_vec;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_arch <= '0;
      lo_arch <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) stage[k] <= HILO_RESET_ENTRY;
    end else begin
      // The oldest stage is past the point of no return and commits even under Flush.
      if (stage[PIPE_DEPTH-1].vhi) hi_arch <= stage[PIPE_DEPTH-1].hi;
      if (stage[PIPE_DEPTH-1].vlo) lo_arch <= stage[PIPE_DEPTH-1].lo;
      for (int unsigned k = 0; k + 1 < PIPE_DEPTH; k++) begin
        stage[k+1] <= hilo_squash(stage[k], Flush);
      end
      stage[0] <= '{vhi: WrHiEn & ~Flush, vlo: WrLoEn & ~Flush, hi: WrHiData, lo: WrLoData};
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      vhi_vec[k] = stage[k].vhi;
      vlo_vec[k] = stage[k].vlo;
      hi_vec[k]  = stage[k].hi;
      lo_vec[k]  = stage[k].lo;
    end
  end

  // Without forwarding the selectors see no valid stages and return arch directly.
  hilo_fwd_sel #(.DEPTH(PIPE_DEPTH), .W(DATA_W)) u_hi_sel (
    .valid (FWD_EN ? vhi_vec : '0),
    .data  (hi_vec),
    .arch  (hi_arch),
    .sel   (HiOut)
  );

  hilo_fwd_sel #(.DEPTH(PIPE_DEPTH), .W(DATA_W)) u_lo_sel (
    .valid (FWD_EN ? vlo_vec : '0),
    .data  (lo_vec),
    .arch  (lo_arch),
    .sel   (LoOut)
  );

  assign Pending = (|vhi_vec) | (|vlo_vec);
  assign Stall   = ~FWD_EN & ((ReadHi & (|vhi_vec)) | (ReadLo & (|vlo_vec)));

endmodule

// File: tb/tb_hilo_reg_unit.sv
// Self-checking bench for hilo_reg_unit; expectations adapt to HILO_FORWARD_EN.
module tb_hilo_reg_unit;

  localparam int unsigned D = 2;
  localparam int unsigned W = 32;
`ifdef HILO_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [31:0] N = 32'hFFFF_FFFE;

  logic          Clk = 1'b0;
  logic          Reset, WrHiEn, WrLoEn, ReadHi, ReadLo, Flush;
  logic [W-1:0]  WrHiData, WrLoData, HiOut, LoOut;
  logic          Stall, Pending;

  always #5 Clk = ~Clk;

  hilo_reg_unit #(.PIPE_DEPTH(D), .DATA_W(W)) dut (
    .Clk(Clk), .Reset(Reset), .WrHiEn(WrHiEn), .WrLoEn(WrLoEn),
    .WrHiData(WrHiData), .WrLoData(WrLoData), .ReadHi(ReadHi), .ReadLo(ReadLo),
    .Flush(Flush), .HiOut(HiOut), .LoOut(LoOut), .Stall(Stall), .Pending(Pending)
  );

  typedef struct {
    logic wh, wl; logic [31:0] hd, ld; logic rh, rl, fl;
    logic [31:0] eh, el; logic es, ep;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic wh, input logic wl, input logic [31:0] hd,
                              input logic [31:0] ld, input logic rh, input logic rl,
                              input logic fl, input logic [31:0] eh, input logic [31:0] el,
                              input logic es, input logic ep);
    vec_t v;
    v = '{wh, wl, hd, ld, rh, rl, fl, eh, el, es, ep};
    tbl.push_back(v);
  endfunction

  function automatic void idle(input logic [31:0] eh, input logic [31:0] el, input logic ep);
    add(0, 0, 0, 0, 0, 0, 0, eh, el, 1'b0, ep);
  endfunction

  task automatic set_in(input logic wh, input logic wl, input logic [31:0] hd,
                        input logic [31:0] ld, input logic rh, input logic rl, input logic fl);
    WrHiEn = wh; WrLoEn = wl; WrHiData = hd; WrLoData = ld;
    ReadHi = rh; ReadLo = rl; Flush = fl;
  endtask

  // madd issue: waits out Stall, reads HI:LO, writes HI:LO + 2*2.
  task automatic madd(output logic [31:0] seen_lo, output int stalls);
    logic [63:0] acc;
    stalls = 0;
    set_in(0, 0, 0, 0, 1, 1, 0);
    #1;
    while (Stall && stalls < 10) begin
      stalls++;
      @(posedge Clk); #2;
    end
    check("madd_stall_bound", 32'(Stall), 32'd0);
    acc = {HiOut, LoOut} + 64'd4;
    seen_lo = LoOut;
    set_in(1, 1, acc[63:32], acc[31:0], 1, 1, 0);
    @(posedge Clk); #1;
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    logic [31:0] lo1, lo2;
    int st1, st2;

    // reset then idle
    repeat (5) idle(0, 0, 0);
    // mult hi=1 lo=FFFFFFFE
    add(1, 1, 32'h1, N, 0, 0, 0, 0, 0, 0, 0);
    idle(FWD ? 32'h1 : 32'h0, FWD ? N : 32'h0, 1);
    idle(FWD ? 32'h1 : 32'h0, FWD ? N : 32'h0, 1);
    idle(32'h1, N, 0);
    // mthi then mtlo on consecutive cycles
    add(1, 0, 32'hAAAA, 0, 0, 0, 0, 32'h1, N, 0, 0);
    add(0, 1, 0, 32'h5555, 0, 0, 0, FWD ? 32'hAAAA : 32'h1, N, 0, 1);
    idle(FWD ? 32'hAAAA : 32'h1, FWD ? 32'h5555 : N, 1);
    idle(32'hAAAA, FWD ? 32'h5555 : N, 1);
    idle(32'hAAAA, 32'h5555, 0);
    // HI = 3
    add(1, 0, 32'h3, 0, 0, 0, 0, 32'hAAAA, 32'h5555, 0, 0);
    idle(FWD ? 32'h3 : 32'hAAAA, 32'h5555, 1);
    idle(FWD ? 32'h3 : 32'hAAAA, 32'h5555, 1);
    idle(32'h3, 32'h5555, 0);
    // write 7, then flush with input 9: both squashed
    add(1, 0, 32'h7, 0, 0, 0, 0, 32'h3, 32'h5555, 0, 0);
    add(1, 0, 32'h9, 0, 0, 0, 1, FWD ? 32'h7 : 32'h3, 32'h5555, 0, 1);
    idle(32'h3, 32'h5555, 0);
    idle(32'h3, 32'h5555, 0);
    // flush while the write sits in the last stage: it commits
    add(1, 0, 32'h11, 0, 0, 0, 0, 32'h3, 32'h5555, 0, 0);
    idle(FWD ? 32'h11 : 32'h3, 32'h5555, 1);
    add(0, 0, 0, 0, 0, 0, 1, FWD ? 32'h11 : 32'h3, 32'h5555, 0, 1);
    idle(32'h11, 32'h5555, 0);
    // mthi 5 then ReadHi: stall for D cycles without forwarding
    add(1, 0, 32'h5, 0, 0, 0, 0, 32'h11, 32'h5555, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, FWD ? 32'h5 : 32'h11, 32'h5555, !FWD, 1);
    add(0, 0, 0, 0, 1, 0, 0, FWD ? 32'h5 : 32'h11, 32'h5555, !FWD, 1);
    add(0, 0, 0, 0, 1, 0, 0, 32'h5, 32'h5555, 0, 0);
    // LO-only hazard
    add(0, 1, 0, 32'h66, 0, 0, 0, 32'h5, 32'h5555, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 32'h5, FWD ? 32'h66 : 32'h5555, !FWD, 1);
    idle(32'h5, FWD ? 32'h66 : 32'h5555, 1);
    idle(32'h5, 32'h66, 0);

    set_in(0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].wh, tbl[i].wl, tbl[i].hd, tbl[i].ld, tbl[i].rh, tbl[i].rl, tbl[i].fl);
      sb.push_back(tbl[i]);
      @(negedge Clk);
      e = sb.pop_front();
      check($sformatf("v%0d_hi", i), HiOut, e.eh);
      check($sformatf("v%0d_lo", i), LoOut, e.el);
      check($sformatf("v%0d_stall", i), 32'(Stall), 32'(e.es));
      check($sformatf("v%0d_pending", i), 32'(Pending), 32'(e.ep));
      @(posedge Clk); #1;
    end

    // clear HI:LO, then two back-to-back madd with A=B=2
    set_in(1, 1, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("clr_hi", HiOut, 32'h0);
    check("clr_lo", LoOut, 32'h0);
    check("clr_pending", 32'(Pending), 32'd0);
    @(posedge Clk); #1;
    madd(lo1, st1);
    madd(lo2, st2);
    check("madd1_read_lo", lo1, 32'h0);
    check("madd1_stalls", 32'(st1), 32'd0);
    check("madd2_read_lo", lo2, 32'h4);
    check("madd2_stalls", 32'(st2), FWD ? 32'd0 : 32'(D));
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("madd_final_hi", HiOut, 32'h0);
    check("madd_final_lo", LoOut, 32'h8);
    check("madd_pending", 32'(Pending), 32'd0);

    // reset mid-operation beats flush and writes; nothing in flight commits
    @(posedge Clk); #1;
    set_in(1, 1, 32'hDEAD, 32'hBEEF, 0, 0, 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    set_in(1, 1, 32'h1234, 32'h1234, 1, 1, 1);
    @(posedge Clk); #1;
    Reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    check("rst_hi", HiOut, 32'h0);
    check("rst_lo", LoOut, 32'h0);
    check("rst_pending", 32'(Pending), 32'd0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_late_hi", HiOut, 32'h0);
    check("rst_late_lo", LoOut, 32'h0);
    check("rst_late_pending", 32'(Pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
